fetch_unit: RTL and testbench

Parametrised instruction-fetch stage that replaces the single-cycle PC register and next-PC mux. It holds the PC and issues instruction reads to the I-cache. A direct-mapped branch target buffer (BTB) with saturating counters predicts the next PC. Execute-stage resolutions update the BTB and redirect fetch on mispredict. The block also owns the sticky halt flag.

---
 rtl/cpu_types_pkg.sv | 9 +
 rtl/fetch_unit_btb.sv | 75 +++++++
 rtl/fetch_unit.sv | 69 ++++++
 tb/tb_fetch_unit.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/cpu_types_pkg.sv
// Shared CPU datapath types and helpers used by the fetch stage.
package cpu_types_pkg;
  localparam int WORD_W = 32;
  typedef logic [WORD_W-1:0] word_t;

  function automatic word_t word_align(input word_t a);
    return {a[WORD_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/fetch_unit_btb.sv
// Direct-mapped branch target buffer: combinational lookup, registered update.
module btb
  import cpu_types_pkg::*;
#(
  parameter int BTB_DEPTH = 16,
  parameter int CTR_W     = 2
) (
  input  logic  CLK,
  input  logic  RST,
  input  word_t lk_pc,
  output logic  lk_hit,
  output logic  lk_taken,
  output word_t lk_target,
  input  logic  up_valid,
  input  word_t up_pc,
  input  logic  up_taken,
  input  word_t up_target
);
  localparam int IDX_W = $clog2(BTB_DEPTH);
  localparam int TAG_W = WORD_W - IDX_W - 2;
  localparam logic [CTR_W-1:0] CTR_MAX  = '1;
  localparam logic [CTR_W-1:0] CTR_WEAK = CTR_W'(1 << (CTR_W - 1));

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    word_t            target;
    logic [CTR_W-1:0] ctr;
  } btb_entry_t;

  btb_entry_t [BTB_DEPTH-1:0] mem_q, mem_d;
  logic [IDX_W-1:0] lk_idx, up_idx;
  logic [TAG_W-1:0] up_tag;
  btb_entry_t       lk_ent, up_ent;
  logic             up_hit;
  logic [3:0]       unused_lo;

  assign unused_lo = {lk_pc[1:0], up_pc[1:0]};

  // Lookup reads registered contents only, so a same-cycle update is not bypassed.
  always_comb begin
    lk_idx    = lk_pc[IDX_W+1:2];
    lk_ent    = mem_q[lk_idx];
    lk_hit    = lk_ent.valid && (lk_ent.tag == lk_pc[WORD_W-1:IDX_W+2]);
    lk_taken  = lk_hit && lk_ent.ctr[CTR_W-1];
    lk_target = lk_ent.target;
  end

  always_comb begin
    mem_d  = mem_q;
    up_idx = up_pc[IDX_W+1:2];
    up_tag = up_pc[WORD_W-1:IDX_W+2];
    up_ent = mem_q[up_idx];
    up_hit = up_ent.valid && (up_ent.tag == up_tag);
    if (up_valid) begin
      if (up_hit && up_taken) begin
        if (up_ent.ctr != CTR_MAX) up_ent.ctr = up_ent.ctr + 1'b1;
        up_ent.target = up_target;
      end else if (up_hit) begin
        if (up_ent.ctr != '0) up_ent.ctr = up_ent.ctr - 1'b1;
      end else if (up_taken) begin
        up_ent.valid  = 1'b1;
        up_ent.tag    = up_tag;
        up_ent.target = up_target;
        up_ent.ctr    = CTR_WEAK;
      end
      mem_d[up_idx] = up_ent;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) mem_q <= '0;
    else     mem_q <= mem_d;
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: PC register, BTB-predicted next PC, mispredict redirect, sticky halt.
module fetch_unit
  import cpu_types_pkg::*;
#(
  parameter word_t PC_INIT   = 32'h0,
  parameter int    BTB_DEPTH = 16,
  parameter int    CTR_W     = 2
) (
  input  logic  CLK,
  input  logic  RST,
  input  logic  ihit,
  input  logic  stall,
  input  logic  halt_req,
  input  logic  res_valid,
  input  word_t res_pc,
  input  logic  res_taken,
  input  word_t res_target,
  input  logic  res_mispredict,
  input  word_t res_next_pc,
  output word_t imemaddr,
  output logic  imemREN,
  output logic  pred_taken,
  output word_t pred_target,
  output logic  halt
);
  word_t pc_q, pc_d;
  logic  halt_q, halt_d;
  logic  bt_hit, bt_taken, redirect;
  word_t bt_target;

  btb #(.BTB_DEPTH(BTB_DEPTH), .CTR_W(CTR_W)) u_btb (
    .CLK       (CLK),
    .RST       (RST),
    .lk_pc     (pc_q),
    .lk_hit    (bt_hit),
    .lk_taken  (bt_taken),
    .lk_target (bt_target),
    .up_valid  (res_valid),
    .up_pc     (res_pc),
    .up_taken  (res_taken),
    .up_target (res_target)
  );

  assign imemaddr    = pc_q;
  assign imemREN     = ~halt_q;
  assign halt        = halt_q;
  assign pred_taken  = bt_hit & bt_taken;
  assign pred_target = pred_taken ? bt_target : pc_q + 32'd4;

  // A redirect arriving with the halt request still lands; after that the PC is frozen.
  always_comb begin
    redirect = res_valid && res_mispredict && (!halt_q || halt_req);
    halt_d   = halt_q | halt_req;
    pc_d     = pc_q;
    if (redirect)                      pc_d = word_align(res_next_pc);
    else if (halt_q || stall || !ihit) pc_d = pc_q;
    else                               pc_d = word_align(pred_target);
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      pc_q   <= word_align(PC_INIT);
      halt_q <= 1'b0;
    end else begin
      pc_q   <= pc_d;
      halt_q <= halt_d;
    end
  end
endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: vector table through a scoreboard queue plus hand-written corner sequences.
module tb_fetch_unit;
  typedef logic [31:0] word_t;

  logic  CLK = 1'b0, RST;
  logic  ihit, stall, halt_req, res_valid, res_taken, res_mispredict;
  word_t res_pc, res_target, res_next_pc;
  word_t imemaddr, pred_target;
  logic  imemREN, pred_taken, halt;

  logic  b_rv, b_rtk;
  word_t b_rpc, b_rtgt;
  word_t b_addr, b_ptgt;
  logic  b_ren, b_pt, b_halt;

  int n_chk = 0;
  int n_err = 0;

  always #5 CLK = ~CLK;

  fetch_unit #(.PC_INIT(32'h100), .BTB_DEPTH(16), .CTR_W(2)) dut (
    .CLK(CLK), .RST(RST), .ihit(ihit), .stall(stall), .halt_req(halt_req),
    .res_valid(res_valid), .res_pc(res_pc), .res_taken(res_taken),
    .res_target(res_target), .res_mispredict(res_mispredict), .res_next_pc(res_next_pc),
    .imemaddr(imemaddr), .imemREN(imemREN), .pred_taken(pred_taken),
    .pred_target(pred_target), .halt(halt)
  );

  fetch_unit #(.PC_INIT(32'h0), .BTB_DEPTH(4), .CTR_W(1)) dut_c1 (
    .CLK(CLK), .RST(RST), .ihit(1'b0), .stall(1'b0), .halt_req(1'b0),
    .res_valid(b_rv), .res_pc(b_rpc), .res_taken(b_rtk),
    .res_target(b_rtgt), .res_mispredict(1'b0), .res_next_pc(32'h0),
    .imemaddr(b_addr), .imemREN(b_ren), .pred_taken(b_pt),
    .pred_target(b_ptgt), .halt(b_halt)
  );

  typedef struct {
    logic  ih, st, hr, rv, rtk, rmis;
    word_t rpc, rtgt, rnx;
    word_t ea;
    logic  ept;
    word_t etg;
    logic  eh;
  } vec_t;

  typedef struct {
    int    id;
    word_t ea;
    logic  ept;
    word_t etg;
    logic  eh;
  } exp_t;

  vec_t vt[$];
  exp_t sb[$];

  function automatic vec_t mk(input logic ih, st, hr, rv, rtk, rmis,
                              input word_t rpc, rtgt, rnx, ea,
                              input logic ept, input word_t etg, input logic eh);
    vec_t v;
    v.ih = ih; v.st = st; v.hr = hr; v.rv = rv; v.rtk = rtk; v.rmis = rmis;
    v.rpc = rpc; v.rtgt = rtgt; v.rnx = rnx;
    v.ea = ea; v.ept = ept; v.etg = etg; v.eh = eh;
    return v;
  endfunction

  task automatic chk(input string name, input word_t act, input word_t exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("Result: errors=%0d of %0d checks", n_err + 1, n_chk + 1);
    $fatal(1, "timeout");
  end

  initial begin
    //          ih st hr rv tk ms rpc           rtgt       rnx            ea            pt etg           h
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,        32'h100,      0, 32'h104,      0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,        32'h104,      0, 32'h108,      0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,        32'h104,      0, 32'h108,      0));
    vt.push_back(mk(1, 1, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,        32'h104,      0, 32'h108,      0));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,        32'h104,      0, 32'h108,      0));
    vt.push_back(mk(0, 0, 0, 1, 1, 0, 32'h108, 32'h200, 32'h0,        32'h108,      0, 32'h10C,      0));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,        32'h108,      1, 32'h200,      0));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 32'h108, 32'h0,   32'h0,        32'h200,      0, 32'h204,      0));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 32'h108, 32'h0,   32'h0,        32'h200,      0, 32'h204,      0));
    vt.push_back(mk(0, 0, 0, 1, 0, 1, 32'h108, 32'h0,   32'h108,      32'h200,      0, 32'h204,      0));
    vt.push_back(mk(0, 0, 0, 1, 1, 0, 32'h108, 32'h200, 32'h0,        32'h108,      0, 32'h10C,      0));
    vt.push_back(mk(0, 0, 0, 1, 1, 0, 32'h108, 32'h200, 32'h0,        32'h108,      0, 32'h10C,      0));
    vt.push_back(mk(0, 0, 0, 1, 1, 0, 32'h108, 32'h200, 32'h0,        32'h108,      1, 32'h200,      0));
    vt.push_back(mk(0, 0, 0, 1, 1, 0, 32'h108, 32'h200, 32'h0,        32'h108,      1, 32'h200,      0));
    vt.push_back(mk(0, 0, 0, 1, 0, 0, 32'h108, 32'h0,   32'h0,        32'h108,      1, 32'h200,      0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,        32'h108,      1, 32'h200,      0));
    vt.push_back(mk(0, 0, 0, 1, 1, 0, 32'h148, 32'h400, 32'h0,        32'h108,      1, 32'h200,      0));
    vt.push_back(mk(0, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,        32'h108,      0, 32'h10C,      0));
    vt.push_back(mk(0, 0, 0, 1, 1, 1, 32'h148, 32'h400, 32'h148,      32'h108,      0, 32'h10C,      0));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,        32'h148,      1, 32'h400,      0));
    vt.push_back(mk(0, 0, 0, 1, 0, 1, 32'h500, 32'h0,   32'h303,      32'h400,      0, 32'h404,      0));
    vt.push_back(mk(0, 0, 0, 1, 0, 1, 32'h500, 32'h0,   32'hFFFFFFFC, 32'h300,      0, 32'h304,      0));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,        32'hFFFFFFFC, 0, 32'h0,        0));
    vt.push_back(mk(0, 1, 1, 1, 0, 1, 32'h500, 32'h0,   32'h300,      32'h0,        0, 32'h4,        0));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,        32'h300,      0, 32'h304,      1));
    vt.push_back(mk(1, 0, 0, 1, 0, 1, 32'h500, 32'h0,   32'h500,      32'h300,      0, 32'h304,      1));
    vt.push_back(mk(1, 0, 0, 0, 0, 0, 32'h0,   32'h0,   32'h0,        32'h300,      0, 32'h304,      1));

    RST = 1'b1;
    {ihit, stall, halt_req, res_valid, res_taken, res_mispredict} = '0;
    res_pc = '0; res_target = '0; res_next_pc = '0;
    b_rv = 1'b0; b_rtk = 1'b0; b_rpc = '0; b_rtgt = '0;
    #12;
    chk("rst_addr", imemaddr, 32'h100);
    chk("rst_ren", {31'b0, imemREN}, 32'h1);
    chk("rst_pt", {31'b0, pred_taken}, 32'h0);
    chk("rst_ptgt", pred_target, 32'h104);
    chk("rst_halt", {31'b0, halt}, 32'h0);
    RST = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < vt.size(); i++) begin
      exp_t e;
      ihit = vt[i].ih; stall = vt[i].st; halt_req = vt[i].hr;
      res_valid = vt[i].rv; res_taken = vt[i].rtk; res_mispredict = vt[i].rmis;
      res_pc = vt[i].rpc; res_target = vt[i].rtgt; res_next_pc = vt[i].rnx;
      e.id = i; e.ea = vt[i].ea; e.ept = vt[i].ept; e.etg = vt[i].etg; e.eh = vt[i].eh;
      sb.push_back(e);
      @(negedge CLK);
      if (sb.size() == 0) chk("sb_empty", 32'h0, 32'h1);
      else begin
        e = sb.pop_front();
        chk($sformatf("v%0d_addr", e.id), imemaddr, e.ea);
        chk($sformatf("v%0d_pt", e.id), {31'b0, pred_taken}, {31'b0, e.ept});
        chk($sformatf("v%0d_ptgt", e.id), pred_target, e.etg);
        chk($sformatf("v%0d_halt", e.id), {31'b0, halt}, {31'b0, e.eh});
        chk($sformatf("v%0d_ren", e.id), {31'b0, imemREN}, {31'b0, ~e.eh});
      end
      @(posedge CLK); #1;
    end

    // Asynchronous reset mid-cycle takes effect without a clock edge.
    {ihit, stall, halt_req, res_valid, res_taken, res_mispredict} = '0;
    #2 RST = 1'b1;
    #1;
    chk("arst_addr", imemaddr, 32'h100);
    chk("arst_halt", {31'b0, halt}, 32'h0);
    chk("arst_ren", {31'b0, imemREN}, 32'h1);
    chk("arst_pt", {31'b0, pred_taken}, 32'h0);
    @(negedge CLK);
    RST = 1'b0;
    @(posedge CLK); #1;

    // Single-bit counter flips prediction on every resolution.
    b_rv = 1'b1; b_rtk = 1'b1; b_rpc = 32'h0; b_rtgt = 32'h80;
    @(negedge CLK);
    chk("c1_miss_pt", {31'b0, b_pt}, 32'h0);
    chk("c1_addr", b_addr, 32'h0);
    @(posedge CLK); #1;
    b_rtk = 1'b0;
    @(negedge CLK);
    chk("c1_alloc_pt", {31'b0, b_pt}, 32'h1);
    chk("c1_alloc_ptgt", b_ptgt, 32'h80);
    @(posedge CLK); #1;
    b_rtk = 1'b1;
    @(negedge CLK);
    chk("c1_nt_pt", {31'b0, b_pt}, 32'h0);
    chk("c1_nt_ptgt", b_ptgt, 32'h4);
    @(posedge CLK); #1;
    b_rv = 1'b0;
    @(negedge CLK);
    chk("c1_t_pt", {31'b0, b_pt}, 32'h1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
